// File: rtl/demux2_sched.sv
// Control-token scheduler for a two-way steering demux: weighted round-robin over
// credit-gated branches, 4-phase rctl/actl handshake. Optional DEMUX2_SCHED_STATS_EN adds per-branch issue counters.
module demux2_sched #(
  parameter int W       = 4,
  parameter int CREDITS = 4,
  parameter int SYNC    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] cfg_w0,
  input  logic [W-1:0] cfg_w1,
  input  logic         cfg_load,
  output logic         rctl_o,
  output logic         dctl_o,
  input  logic         actl_i,
  input  logic         cred0_i,
  input  logic         cred1_i,
  output logic         busy_o,
  output logic         err_o,
  output logic [15:0]  cnt0_o,
  output logic [15:0]  cnt1_o
);
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CMAX = CW'(CREDITS);

  typedef enum logic [1:0] {IDLE, SETUP, REQ, RTZ} state_t;

  state_t        state_q, state_d;
  logic          cur_q, cur_d;
  logic [W-1:0]  run_q, run_d;
  logic [W-1:0]  w0_q, w0_d, w1_q, w1_d;
  logic [CW-1:0] cr0_q, cr0_d, cr1_q, cr1_d;
  logic          rctl_q, rctl_d, dctl_q, dctl_d;
  logic          err_q, err_d;
  logic [SYNC-1:0] sync_q;
  logic          actl_s;
  logic          issue0, issue1, ovf0, ovf1;
  logic          elig0, elig1, cur_elig, oth_elig;
  logic [W-1:0]  cur_w;

  assign actl_s = sync_q[SYNC-1];

  assign elig0    = (w0_q != '0) && (cr0_q != '0);
  assign elig1    = (w1_q != '0) && (cr1_q != '0);
  assign cur_elig = cur_q ? elig1 : elig0;
  assign oth_elig = cur_q ? elig0 : elig1;
  assign cur_w    = cur_q ? w1_q : w0_q;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    run_d   = run_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    dctl_d  = dctl_q;
    rctl_d  = rctl_q;
    issue0  = 1'b0;
    issue1  = 1'b0;
    case (state_q)
      IDLE: begin
        // A load consumes its cycle; scheduling resumes with the new weights next cycle.
        if (cfg_load) begin
          w0_d  = cfg_w0;
          w1_d  = cfg_w1;
          run_d = '0;
          cur_d = 1'b0;
        end else if (en && (elig0 || elig1)) begin
          if (cur_elig && (run_q < cur_w)) begin
            dctl_d = cur_q;
          end else if (oth_elig) begin
            dctl_d = ~cur_q;
            cur_d  = ~cur_q;
            run_d  = '0;
          end else begin
            dctl_d = cur_q;
            run_d  = '0;
          end
          state_d = SETUP;
        end
      end
      SETUP: begin
        rctl_d  = 1'b1;
        run_d   = run_q + W'(1);
        issue0  = ~dctl_q;
        issue1  = dctl_q;
        state_d = REQ;
      end
      REQ: begin
        if (actl_s) begin
          rctl_d  = 1'b0;
          state_d = RTZ;
        end
      end
      RTZ: begin
        if (!actl_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous issue and return cancel; a return at full credit saturates and flags.
  always_comb begin
    cr0_d = cr0_q;
    cr1_d = cr1_q;
    ovf0  = 1'b0;
    ovf1  = 1'b0;
    case ({issue0, cred0_i})
      2'b10:   cr0_d = cr0_q - CW'(1);
      2'b01:   if (cr0_q == CMAX) ovf0 = 1'b1; else cr0_d = cr0_q + CW'(1);
      default: cr0_d = cr0_q;
    endcase
    case ({issue1, cred1_i})
      2'b10:   cr1_d = cr1_q - CW'(1);
      2'b01:   if (cr1_q == CMAX) ovf1 = 1'b1; else cr1_d = cr1_q + CW'(1);
      default: cr1_d = cr1_q;
    endcase
    err_d = err_q | ovf0 | ovf1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= 1'b0;
      run_q   <= '0;
      w0_q    <= W'(1);
      w1_q    <= W'(1);
      cr0_q   <= CMAX;
      cr1_q   <= CMAX;
      rctl_q  <= 1'b0;
      dctl_q  <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      run_q   <= run_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      cr0_q   <= cr0_d;
      cr1_q   <= cr1_d;
      rctl_q  <= rctl_d;
      dctl_q  <= dctl_d;
      err_q   <= err_d;
      sync_q  <= {sync_q[SYNC-2:0], actl_i};
    end
  end

  assign rctl_o = rctl_q;
  assign dctl_o = dctl_q;
  assign busy_o = (state_q != IDLE);
  assign err_o  = err_q;

`ifdef DEMUX2_SCHED_STATS_EN
  logic [15:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (issue0) cnt0_q <= cnt0_q + 16'd1;
      if (issue1) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign cnt0_o = cnt0_q;
  assign cnt1_o = cnt1_q;
`else
  assign cnt0_o = '0;
  assign cnt1_o = '0;
`endif
endmodule

// File: tb/tb_demux2_sched.sv
// Randomized self-checking bench for demux2_sched against a rule-level scheduling model.
module tb_demux2_sched;
  localparam int W = 4, CREDITS = 4, SYNC = 2;

  logic clk = 1'b0;
  logic rst, en, cfg_load, actl, cred0, cred1;
  logic [W-1:0] cfg_w0, cfg_w1;
  logic rctl, dctl, busy, err;
  logic [15:0] cnt0, cnt1;

  int checks = 0, failures = 0;
  int mw[2], mcr[2], mcnt[2];
  int mcur, mrun;

  demux2_sched #(.W(W), .CREDITS(CREDITS), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_w0(cfg_w0), .cfg_w1(cfg_w1), .cfg_load(cfg_load),
    .rctl_o(rctl), .dctl_o(dctl), .actl_i(actl), .cred0_i(cred0), .cred1_i(cred1),
    .busy_o(busy), .err_o(err), .cnt0_o(cnt0), .cnt1_o(cnt1)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    mw   = '{1, 1};
    mcr  = '{CREDITS, CREDITS};
    mcnt = '{0, 0};
    mcur = 0;
    mrun = 0;
  endfunction

  function automatic bit model_elig(int b);
    return (mw[b] != 0) && (mcr[b] > 0);
  endfunction

  // Branch choice straight from the scheduling rules; -1 means nothing eligible.
  function automatic int model_pick();
    if (!model_elig(0) && !model_elig(1)) return -1;
    if (model_elig(mcur) && mrun < mw[mcur]) return mcur;
    mrun = 0;
    if (model_elig(1 - mcur)) mcur = 1 - mcur;
    return mcur;
  endfunction

  function automatic void model_return(int b);
    if (mcr[b] < CREDITS) mcr[b]++;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; en = 0; actl = 0; cred0 = 0; cred1 = 0; cfg_load = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin @(negedge clk); n++; end
    if (busy) check("idle_timeout", busy, 0);
  endtask

  task automatic load(input int w0, input int w1);
    en = 0;
    @(negedge clk);
    wait_idle();
    cfg_w0 = W'(w0); cfg_w1 = W'(w1); cfg_load = 1;
    @(negedge clk);
    cfg_load = 0;
    mw = '{w0, w1}; mcur = 0; mrun = 0;
  endtask

  task automatic pulse_cred(input int b);
    @(negedge clk);
    if (b == 1) cred1 = 1; else cred0 = 1;
    @(negedge clk);
    cred0 = 0; cred1 = 0;
    model_return(b);
  endtask

  // Acts as the acknowledging environment for one token; optionally returns its credit.
  task automatic run_token(input bit ret0, input bit ret1, input bit last, output int br);
    int exp, n;
    exp = model_pick();
    n = 0;
    while (!rctl && n < 40) begin @(negedge clk); n++; end
    if (!rctl) begin
      check("rise_timeout", rctl, 1);
      br = -1;
      return;
    end
    br = int'(dctl);
    check("branch", dctl, exp);
    check("busy_req", busy, 1);
    if (last) en = 0;
    if (exp >= 0) begin mcr[exp]--; mrun++; mcnt[exp]++; end
    actl = 1;
    if (exp == 0 && ret0) cred0 = 1;
    if (exp == 1 && ret1) cred1 = 1;
    @(negedge clk);
    if (cred0) model_return(0);
    if (cred1) model_return(1);
    cred0 = 0; cred1 = 0;
    n = 0;
    while (rctl && n < 40) begin @(negedge clk); n++; end
    if (rctl) check("fall_timeout", rctl, 0);
    check("dctl_hold", dctl, br);
    actl = 0;
  endtask

  task automatic run_tokens(input int cnt, input bit ret0, input bit ret1);
    int b;
    en = 1;
    for (int i = 0; i < cnt; i++) run_token(ret0, ret1, i == cnt - 1, b);
  endtask

  initial begin : main
    int b, n0, seen;
    int seq1[6] = '{0, 0, 1, 0, 0, 1};
    int exp_cnt;
    cfg_w0 = '0; cfg_w1 = '0;
    do_reset();
    @(negedge clk);
    check("rst_rctl", rctl, 0);
    check("rst_dctl", dctl, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);

    // Weighted 2:1 with immediate credit return.
    load(2, 1);
    en = 1;
    for (int i = 0; i < 6; i++) begin
      run_token(1, 1, i == 5, b);
      check("wrr_2_1_seq", b, seq1[i]);
    end

    // Branch 0 starves on credits; branch 1 keeps going with new turns.
    load(3, 3);
    en = 1;
    n0 = 0;
    for (int i = 0; i < 12; i++) begin
      run_token(0, 1, i == 11, b);
      if (b == 0) n0++;
    end
    check("starve_b0_tokens", n0, 4);
    wait_idle();
    pulse_cred(0);
    en = 1;
    n0 = 0;
    for (int i = 0; i < 3; i++) begin
      run_token(0, 1, i == 2, b);
      if (b == 0) n0++;
    end
    check("cred0_reselect", n0, 1);

    // Overflowing return on a full branch.
    wait_idle();
    check("model_b1_full", mcr[1], CREDITS);
    pulse_cred(1);
    check("err_set", err, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", err, 1);

    // Zero weights never issue.
    load(0, 0);
    en = 1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rctl || busy) seen++;
    end
    check("w00_idle", seen, 0);
    en = 0;

    // Reset in the middle of a request.
    load(1, 1);
    en = 1;
    begin
      int n = 0;
      while (!rctl && n < 40) begin @(negedge clk); n++; end
    end
    check("pre_rst_rctl", rctl, 1);
    rst = 1; en = 0;
    @(negedge clk);
    check("midrst_rctl", rctl, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    rst = 0;
    model_reset();
    load(1, 0);
    run_tokens(CREDITS, 0, 0);
    wait_idle();
    en = 1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rctl) seen++;
    end
    check("credits_exhausted", seen, 0);
    en = 0;

    // Issue counters over ten alternating tokens.
    do_reset();
    run_tokens(10, 1, 1);
    wait_idle();
`ifdef DEMUX2_SCHED_STATS_EN
    exp_cnt = 5;
`else
    exp_cnt = 0;
`endif
    check("stats_cnt0", cnt0, exp_cnt);
    check("stats_cnt1", cnt1, exp_cnt);

    // Randomized weights, credit returns and credit starvation.
    begin
      int w0, w1;
      w0 = $urandom_range(0, 3);
      w1 = (w0 == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
      load(w0, w1);
    end
    en = 1;
    for (int i = 0; i < 40; i++) begin
      if (!model_elig(0) && !model_elig(1)) pulse_cred((mw[0] != 0) ? 0 : 1);
      run_token(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i == 39, b);
    end
    wait_idle();
    check("rand_err", err, 0);
`ifdef DEMUX2_SCHED_STATS_EN
    check("rand_cnt0", cnt0, mcnt[0] & 16'hFFFF);
    check("rand_cnt1", cnt1, mcnt[1] & 16'hFFFF);
`else
    check("rand_cnt0", cnt0, 0);
    check("rand_cnt1", cnt1, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
